// File: rtl/rv32_shift_pkg.sv
// Shared types and encodings for the RV32 shift issue stage.
// SHIFT_ILLEGAL_TRAP_EN adds an illegal flag to the decoded control bundle.
package rv32_shift_pkg;

  localparam int XLEN    = 32;
  localparam int SHAMT_W = 5;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

  localparam logic [2:0] F3_SLL = 3'b001;
  localparam logic [2:0] F3_SR  = 3'b101;

  localparam logic [6:0] F7_LOGIC = 7'b0000000;
  localparam logic [6:0] F7_ARITH = 7'b0100000;

  typedef struct packed {
    logic enable;
    logic logical;
    logic direction;
    logic immediate;
`ifdef SHIFT_ILLEGAL_TRAP_EN
    logic illegal;
`endif
  } shift_ctrl_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } skid_state_e;

  typedef struct packed {
    shift_ctrl_t     ctrl;
    logic [XLEN-1:0] code_bus;
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
  } issue_entry_t;

endpackage

// File: rtl/rv32_shift_decode.sv
// Combinational classifier: instruction word -> shifter control bundle.
// SHIFT_ILLEGAL_TRAP_EN flags malformed shift encodings instead of issuing them silently.
module rv32_shift_decode
  import rv32_shift_pkg::*;
(
  input  logic [XLEN-1:0] instr,
  output shift_ctrl_t     ctrl
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       is_op;
  logic       is_op_imm;

  assign opcode    = instr[6:0];
  assign funct3    = instr[14:12];
  assign funct7    = instr[31:25];
  assign is_op     = (opcode == OPC_OP);
  assign is_op_imm = (opcode == OPC_OP_IMM);

  // funct7 is checked on instr[31:25] for OP-IMM too, so shamt[5] = 1 never decodes as a shift
  always_comb begin
    ctrl = '0;
    if (is_op || is_op_imm) begin
      if (funct3 == F3_SLL && funct7 == F7_LOGIC) begin
        ctrl.enable    = 1'b1;
        ctrl.logical   = 1'b1;
        ctrl.immediate = is_op_imm;
      end else if (funct3 == F3_SR && funct7 == F7_LOGIC) begin
        ctrl.enable    = 1'b1;
        ctrl.logical   = 1'b1;
        ctrl.direction = 1'b1;
        ctrl.immediate = is_op_imm;
      end else if (funct3 == F3_SR && funct7 == F7_ARITH) begin
        ctrl.enable    = 1'b1;
        ctrl.direction = 1'b1;
        ctrl.immediate = is_op_imm;
      end
`ifdef SHIFT_ILLEGAL_TRAP_EN
      else if (funct3 == F3_SLL || funct3 == F3_SR) begin
        ctrl.illegal = 1'b1;
      end
`endif
    end
  end

endmodule

// File: rtl/rv32_shift_issue_stage.sv
// Shift issue stage: decodes ID instructions and hands shifter bundles to EX via a 2-entry skid buffer.
// SHIFT_ILLEGAL_TRAP_EN adds the registered out_illegal output.
module rv32_shift_issue_stage
  import rv32_shift_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_instr,
  input  logic [XLEN-1:0] in_rs1,
  input  logic [XLEN-1:0] in_rs2,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            out_enable,
  output logic            out_logical,
  output logic            out_direction,
  output logic            out_immediate,
`ifdef SHIFT_ILLEGAL_TRAP_EN
  output logic            out_illegal,
`endif
  output logic [XLEN-1:0] out_code_bus,
  output logic [XLEN-1:0] out_rs1,
  output logic [XLEN-1:0] out_rs2
);

  shift_ctrl_t  dec_ctrl;
  issue_entry_t in_entry;
  issue_entry_t main_q;
  issue_entry_t skid_q;
  skid_state_e  state_q;
  skid_state_e  state_d;
  logic         in_ready_q;
  logic         accept;
  logic         consume;
  logic         load_main;
  logic         load_skid;
  logic         main_from_skid;

  rv32_shift_decode u_decode (
    .instr (in_instr),
    .ctrl  (dec_ctrl)
  );

  always_comb begin
    in_entry          = '0;
    in_entry.ctrl     = dec_ctrl;
    in_entry.code_bus = in_instr;
    in_entry.rs1      = in_rs1;
    in_entry.rs2      = {{(XLEN-SHAMT_W){1'b0}}, in_rs2[SHAMT_W-1:0]};
  end

  // Flush gates both handshakes so a same-cycle input is dropped and nothing is popped
  assign out_valid = (state_q != EMPTY);
  assign accept    = in_valid && in_ready_q && !flush;
  assign consume   = out_valid && out_ready && !flush;

  always_comb begin
    state_d        = state_q;
    load_main      = 1'b0;
    load_skid      = 1'b0;
    main_from_skid = 1'b0;
    case (state_q)
      EMPTY: begin
        if (accept) begin
          state_d   = ONE;
          load_main = 1'b1;
        end
      end
      ONE: begin
        if (accept && consume) begin
          load_main = 1'b1;
        end else if (accept) begin
          state_d   = FULL;
          load_skid = 1'b1;
        end else if (consume) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (consume) begin
          state_d        = ONE;
          main_from_skid = 1'b1;
        end
      end
      default: state_d = EMPTY;
    endcase
    if (flush) begin
      state_d = EMPTY;
    end
  end

  // in_ready is registered from the next state so it drops on the same edge the buffer fills
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= EMPTY;
      in_ready_q <= 1'b1;
      main_q     <= '0;
      skid_q     <= '0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d != FULL);
      if (load_main) begin
        main_q <= in_entry;
      end else if (main_from_skid) begin
        main_q <= skid_q;
      end
      if (load_skid) begin
        skid_q <= in_entry;
      end
    end
  end

  assign in_ready      = in_ready_q;
  assign out_enable    = main_q.ctrl.enable;
  assign out_logical   = main_q.ctrl.logical;
  assign out_direction = main_q.ctrl.direction;
  assign out_immediate = main_q.ctrl.immediate;
`ifdef SHIFT_ILLEGAL_TRAP_EN
  assign out_illegal   = main_q.ctrl.illegal;
`endif
  assign out_code_bus  = main_q.code_bus;
  assign out_rs1       = main_q.rs1;
  assign out_rs2       = main_q.rs2;

endmodule
